// File: rtl/lcd_bus_timing.sv
// HD44780 8-bit write-only bus sequencer: setup, EN pulse, hold and execution wait per byte.
// Define LCD_INIT_SEQ_EN to run the power-up delay and the 7-byte init sequence after every reset.
module lcd_bus_timing #(
   parameter int T_POWERUP   = 750000,
   parameter int T_SETUP     = 2,
   parameter int T_EN        = 23,
   parameter int T_HOLD      = 2,
   parameter int T_EXEC      = 2000,
   parameter int T_EXEC_LONG = 82000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       init_done,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic [7:0] LCD_DATA
);

   // A zero-length phase is stretched to one cycle so every state is visited.
   localparam int P_POWERUP   = (T_POWERUP   < 1) ? 1 : T_POWERUP;
   localparam int P_SETUP     = (T_SETUP     < 1) ? 1 : T_SETUP;
   localparam int P_EN        = (T_EN        < 1) ? 1 : T_EN;
   localparam int P_HOLD      = (T_HOLD      < 1) ? 1 : T_HOLD;
   localparam int P_EXEC      = (T_EXEC      < 1) ? 1 : T_EXEC;
   localparam int P_EXEC_LONG = (T_EXEC_LONG < 1) ? 1 : T_EXEC_LONG;

   localparam int MAX_A = (P_POWERUP > P_EXEC_LONG) ? P_POWERUP : P_EXEC_LONG;
   localparam int MAX_B = (P_EXEC > P_EN) ? P_EXEC : P_EN;
   localparam int MAX_C = (P_SETUP > P_HOLD) ? P_SETUP : P_HOLD;
   localparam int MAX_D = (MAX_B > MAX_C) ? MAX_B : MAX_C;
   localparam int MAX_T = (MAX_A > MAX_D) ? MAX_A : MAX_D;
   localparam int CNT_W = $clog2(MAX_T + 1);

   typedef enum logic [2:0] {
      POWERUP,
      INIT_ISSUE,
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      EXEC
   } state_t;

`ifdef LCD_INIT_SEQ_EN
   localparam state_t RESET_STATE = POWERUP;
   localparam logic [2:0] ROM_LEN = 3'd7;

   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      logic [7:0] val;
      case (idx)
         3'd0, 3'd1, 3'd2, 3'd3: val = 8'h38;
         3'd4:                   val = 8'h0C;
         3'd5:                   val = 8'h01;
         3'd6:                   val = 8'h06;
         default:                val = 8'h00;
      endcase
      return val;
   endfunction

   logic [2:0] rom_idx_reg;
`else
   localparam state_t RESET_STATE = IDLE;
`endif

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             rs_reg;
   logic [7:0]       data_reg;
   logic             en_reg;
   logic             wr_ready_reg;
   logic             init_done_reg;
   logic             long_exec_reg;
   logic [CNT_W-1:0] exec_last;

   assign exec_last = long_exec_reg ? CNT_W'(P_EXEC_LONG - 1) : CNT_W'(P_EXEC - 1);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg     <= RESET_STATE;
         cnt_reg       <= '0;
         rs_reg        <= 1'b0;
         data_reg      <= 8'h00;
         en_reg        <= 1'b0;
         wr_ready_reg  <= 1'b0;
         init_done_reg <= 1'b0;
         long_exec_reg <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
         rom_idx_reg   <= 3'd0;
`endif
      end else begin
         case (state_reg)
`ifdef LCD_INIT_SEQ_EN
            POWERUP: begin
               if (cnt_reg == CNT_W'(P_POWERUP - 1)) begin
                  state_reg <= INIT_ISSUE;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            INIT_ISSUE: begin
               rs_reg      <= 1'b0;
               data_reg    <= init_rom(rom_idx_reg);
               rom_idx_reg <= rom_idx_reg + 3'd1;
               state_reg   <= SETUP;
               cnt_reg     <= '0;
            end
`endif
            IDLE: begin
               // Only reachable with init_done=0 when there is no init sequence.
               if (!init_done_reg) begin
                  init_done_reg <= 1'b1;
                  wr_ready_reg  <= 1'b1;
               end else if (wr_valid && wr_ready_reg) begin
                  rs_reg       <= wr_rs;
                  data_reg     <= wr_data;
                  wr_ready_reg <= 1'b0;
                  state_reg    <= SETUP;
                  cnt_reg      <= '0;
               end
            end
            SETUP: begin
               if (cnt_reg == CNT_W'(P_SETUP - 1)) begin
                  state_reg <= PULSE;
                  en_reg    <= 1'b1;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            PULSE: begin
               if (cnt_reg == CNT_W'(P_EN - 1)) begin
                  state_reg <= HOLD;
                  en_reg    <= 1'b0;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            HOLD: begin
               if (cnt_reg == CNT_W'(P_HOLD - 1)) begin
                  state_reg     <= EXEC;
                  cnt_reg       <= '0;
                  // Clear display and return home need the long execution wait.
                  long_exec_reg <= !rs_reg && (data_reg == 8'h01 || data_reg == 8'h02 ||
                                               data_reg == 8'h03);
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            EXEC: begin
               if (cnt_reg == exec_last) begin
                  cnt_reg <= '0;
`ifdef LCD_INIT_SEQ_EN
                  if (rom_idx_reg != ROM_LEN) begin
                     state_reg <= INIT_ISSUE;
                  end else begin
                     state_reg     <= IDLE;
                     init_done_reg <= 1'b1;
                     wr_ready_reg  <= 1'b1;
                  end
`else
                  state_reg    <= IDLE;
                  wr_ready_reg <= 1'b1;
`endif
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               state_reg <= RESET_STATE;
               cnt_reg   <= '0;
               en_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign wr_ready  = wr_ready_reg;
   assign init_done = init_done_reg;
   assign LCD_RS    = rs_reg;
   assign LCD_RW    = 1'b0;
   assign LCD_EN    = en_reg;
   assign LCD_DATA  = data_reg;

endmodule

// File: tb/tb_lcd_bus_timing.sv
// Self-checking bench for lcd_bus_timing: vector table, corner sequences and random writes
// checked against a timing model; covers both LCD_INIT_SEQ_EN builds.
module tb_lcd_bus_timing;

   localparam int T_POWERUP   = 20;
   localparam int T_SETUP     = 2;
   localparam int T_EN        = 4;
   localparam int T_HOLD      = 2;
   localparam int T_EXEC      = 10;
   localparam int T_EXEC_LONG = 40;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       init_done;
   logic       LCD_RS, LCD_RW, LCD_EN;
   logic [7:0] LCD_DATA;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   lcd_bus_timing #(
      .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
      .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG)
   ) dut (
      .Clock(Clock), .Reset(Reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_rs(wr_rs), .wr_data(wr_data), .init_done(init_done),
      .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // EN pulse recorder: rise cycle, {RS,DATA} at rise, width in cycles.
   int   rise_q[$];
   int   pdat_q[$];
   int   width_q[$];
   int   rise_c = 0;
   logic prev_en = 1'b0;
   always @(negedge Clock) begin
      if (LCD_EN && !prev_en) begin
         rise_q.push_back(cyc);
         pdat_q.push_back(int'({LCD_RS, LCD_DATA}));
         rise_c = cyc;
      end
      if (!LCD_EN && prev_en) width_q.push_back(cyc - rise_c);
      prev_en = LCD_EN;
   end

   // Reference timing: execution wait depends only on the written byte.
   function automatic int model_exec(input logic rs, input logic [7:0] d);
      return (!rs && d >= 8'h01 && d <= 8'h03) ? T_EXEC_LONG : T_EXEC;
   endfunction

   function automatic int model_delay(input logic rs, input logic [7:0] d);
      return T_SETUP + T_EN + T_HOLD + model_exec(rs, d);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_ready(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (wr_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge Clock);
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: wr_ready timeout, got 0 expected 1", name);
      end
   endtask

   task automatic do_write(input logic rs, input logic [7:0] d, input int exp_delay,
                           input string tag);
      int c0, n0;
      bit ok;
      wait_ready({tag, "_pre"}, ok);
      if (!ok) return;
      n0 = rise_q.size();
      wr_valid = 1'b1;
      wr_rs    = rs;
      wr_data  = d;
      @(negedge Clock);
      c0 = cyc;
      wr_valid = 1'b0;
      check({tag, "_rs"}, int'(LCD_RS), int'(rs));
      check({tag, "_data"}, int'(LCD_DATA), int'(d));
      check({tag, "_busy"}, int'(wr_ready), 0);
      wait_ready({tag, "_post"}, ok);
      if (!ok) return;
      check({tag, "_ready_delay"}, cyc - c0, exp_delay);
      check({tag, "_pulses"}, rise_q.size() - n0, 1);
      if (rise_q.size() == n0 + 1 && width_q.size() > n0) begin
         check({tag, "_en_rise"}, rise_q[n0] - c0, T_SETUP);
         check({tag, "_en_width"}, width_q[n0], T_EN);
      end
      check({tag, "_rw"}, int'(LCD_RW), 0);
      $display("write %s rs=%0d data=%02h ready_after=%0d", tag, rs, d, cyc - c0);
   endtask

`ifdef LCD_INIT_SEQ_EN
   task automatic verify_init(input int base, input string tag);
      logic [7:0] rom [7];
      bit done = 1'b0;
      rom = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      for (int i = 0; i < 1000; i++) begin
         if (init_done) begin
            done = 1'b1;
            break;
         end
         check({tag, "_ready_during_init"}, int'(wr_ready), 0);
         @(negedge Clock);
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_init_done: timeout, got 0 expected 1", tag);
         return;
      end
      check({tag, "_ready_after_init"}, int'(wr_ready), 1);
      check({tag, "_init_pulses"}, rise_q.size() - base, 7);
      if (rise_q.size() - base != 7 || width_q.size() < base + 7) return;
      for (int k = 0; k < 7; k++) begin
         check({tag, "_init_byte"}, pdat_q[base + k], int'({1'b0, rom[k]}));
         check({tag, "_init_width"}, width_q[base + k], T_EN);
         if (k > 0)
            check({tag, "_init_gap"}, rise_q[base + k] - rise_q[base + k - 1],
                  1 + T_SETUP + T_EN + T_HOLD + model_exec(1'b0, rom[k - 1]));
         $display("init %s entry=%0d data=%02h rise=%0d", tag, k, rom[k], rise_q[base + k]);
      end
   endtask
`endif

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         delay;
   } vec_t;

   initial begin
      vec_t vecs [8];
      bit   ok;
      int   c0, c1, n0;
      logic       rrs;
      logic [7:0] rd;

      vecs = '{'{1'b1, 8'h41, 18}, '{1'b0, 8'h01, 48}, '{1'b1, 8'h01, 18},
               '{1'b0, 8'h02, 48}, '{1'b0, 8'h03, 48}, '{1'b0, 8'h04, 18},
               '{1'b0, 8'h00, 18}, '{1'b1, 8'h03, 18}};

      // Reset state, held for 3 cycles.
      repeat (3) begin
         @(negedge Clock);
         check("rst_en", int'(LCD_EN), 0);
         check("rst_ready", int'(wr_ready), 0);
         check("rst_init_done", int'(init_done), 0);
         check("rst_data", int'(LCD_DATA), 0);
         check("rst_rs", int'(LCD_RS), 0);
         check("rst_rw", int'(LCD_RW), 0);
      end
      Reset = 1'b0;
      @(negedge Clock);
`ifdef LCD_INIT_SEQ_EN
      verify_init(0, "boot");
`else
      check("boot_init_done", int'(init_done), 1);
      check("boot_ready", int'(wr_ready), 1);
      repeat (5) @(negedge Clock);
      check("boot_no_en", rise_q.size(), 0);
`endif

      for (int i = 0; i < 8; i++)
         do_write(vecs[i].rs, vecs[i].data, vecs[i].delay, $sformatf("vec%0d", i));

      // Request held while busy; only the value present when ready rises is taken.
      wait_ready("hold_pre", ok);
      n0 = rise_q.size();
      wr_valid = 1'b1;
      wr_rs    = 1'b1;
      wr_data  = 8'h77;
      @(negedge Clock);
      c0 = cyc;
      wr_data = 8'h55;
      repeat (9) @(negedge Clock);
      check("hold_busy", int'(wr_ready), 0);
      wr_data = 8'h66;
      wait_ready("hold_mid", ok);
      check("hold_ready_delay", cyc - c0, model_delay(1'b1, 8'h77));
      @(negedge Clock);
      wr_valid = 1'b0;
      check("hold_data", int'(LCD_DATA), 8'h66);
      wait_ready("hold_post", ok);
      check("hold_pulses", rise_q.size() - n0, 2);
      if (rise_q.size() == n0 + 2) begin
         check("hold_first", pdat_q[n0], int'({1'b1, 8'h77}));
         check("hold_second", pdat_q[n0 + 1], int'({1'b1, 8'h66}));
      end
      $display("write hold rs=1 data=77 then 66 (55 ignored)");

      // Randomized writes, biased towards the long-exec commands.
      for (int i = 0; i < 20; i++) begin
         rrs = 1'($urandom_range(0, 1));
         rd  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
         do_write(rrs, rd, model_delay(rrs, rd), $sformatf("rnd%0d", i));
      end

      // Reset during the EN pulse.
      wait_ready("abort_pre", ok);
      wr_valid = 1'b1;
      wr_rs    = 1'b1;
      wr_data  = 8'h5A;
      @(negedge Clock);
      wr_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (LCD_EN) begin
            ok = 1'b1;
            break;
         end
         @(negedge Clock);
      end
      check("abort_saw_en", int'(ok), 1);
      Reset = 1'b1;
      @(negedge Clock);
      check("abort_en", int'(LCD_EN), 0);
      check("abort_ready", int'(wr_ready), 0);
      check("abort_init_done", int'(init_done), 0);
      check("abort_data", int'(LCD_DATA), 0);
      @(negedge Clock);
      Reset = 1'b0;
      n0 = rise_q.size();
      @(negedge Clock);
      $display("reset asserted mid-pulse, pulses so far=%0d", n0);
`ifdef LCD_INIT_SEQ_EN
      verify_init(n0, "reinit");
`else
      check("reinit_init_done", int'(init_done), 1);
      check("reinit_ready", int'(wr_ready), 1);
      repeat (8) @(negedge Clock);
      check("reinit_no_repulse", rise_q.size(), n0);
`endif
      c1 = cyc;
      do_write(1'b1, 8'h42, model_delay(1'b1, 8'h42), "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
